// File: rtl/apb_slv_regfile.sv
// APB3 completer holding a bank of 32-bit registers with configurable wait
// states, decode-error reporting on pslverr and a sticky protocol-violation flag.
module apb_slv_regfile #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic [31:0]              pwdata,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic                     prot_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic                       write_q, write_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       prot_q, prot_d;
    logic [NUM_REGS-1:1][31:0]  regs_q, regs_d;

    logic [NUM_REGS-1:0][31:0]  words_c;
    logic [IDX_W-1:0]           idx_c;
    logic                       valid_c;
    logic                       err_c;
    logic                       pready_c;
    logic                       mism_c;
    logic                       wr_en_c;

    // Decode of the latched transfer; the access phase always uses latched values
    assign idx_c    = addr_q[ADDR_W-1:2];
    assign valid_c  = (addr_q[1:0] == 2'b00) && (32'(idx_c) < NUM_REGS);
    assign err_c    = !valid_c || (write_q && (idx_c == '0));
    assign pready_c = (state_q == ST_ACCESS) && psel && penable && (wcnt_q == '0);
    assign mism_c   = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);

    // Word view: word 0 is the constant ID, the rest are writable registers
    assign words_c[0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_word
        assign words_c[g] = regs_q[g];
        assign regs_d[g]  = (wr_en_c && (idx_c == IDX_W'(g))) ? wdata_q : regs_q[g];
    end

    assign reg_out  = words_c;
    assign pready   = pready_c;
    assign pslverr  = pready_c && err_c;
    assign prdata   = (pready_c && !write_q && !err_c) ? words_c[idx_c[SEL_W-1:0]] : 32'h0;
    assign prot_err = prot_q;

    // FSM state, wait counter, latched transfer and sticky flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            prot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            prot_q  <= prot_d;
        end
    end

    // Register bank; commits only on a completing, error-free write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Next-state: setup capture, wait countdown, completion and violation tracking
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        prot_d  = prot_q;
        wr_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (penable) begin
                    prot_d = 1'b1;
                end else if (psel) begin
                    state_d = ST_ACCESS;
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    wcnt_d  = CNT_W'(WAIT_STATES);
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    // Master abandoned the transfer: abort without writing
                    prot_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (!penable || mism_c) begin
                        prot_d = 1'b1;
                    end
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - CNT_W'(1);
                    end else if (penable) begin
                        state_d = ST_IDLE;
                        wr_en_c = write_q && !err_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_slv_regfile.sv
// Bench for apb_slv_regfile: three instances (0, 3 and 2 wait states) driven by
// directed APB transfers, checked every cycle against a transaction-level model.
module tb_apb_slv_regfile;

    localparam int          NREG = 8;
    localparam logic [31:0] ID   = 32'hA9B0_0001;

    logic        clk;
    logic        reset;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [11:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [255:0] reg_out [3];
    logic        prot_err [3];

    // Model state and per-cycle expectations
    logic [31:0] mreg    [3][NREG];
    logic        mprot   [3];
    logic        exp_rdy [3];
    logic [31:0] exp_rd  [3];
    logic        exp_err [3];

    // Observations of the most recent transfer per instance
    int          last_lat [3];
    logic [31:0] last_rd  [3];
    logic        last_err [3];

    int checks = 0;
    int errors = 0;

    apb_slv_regfile #(.ADDR_W(12), .NUM_REGS(NREG), .WAIT_STATES(0), .ID_VALUE(ID)) u_ws0 (
        .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .reg_out(reg_out[0]), .prot_err(prot_err[0]));

    apb_slv_regfile #(.ADDR_W(12), .NUM_REGS(NREG), .WAIT_STATES(3), .ID_VALUE(ID)) u_ws3 (
        .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .reg_out(reg_out[1]), .prot_err(prot_err[1]));

    apb_slv_regfile #(.ADDR_W(12), .NUM_REGS(NREG), .WAIT_STATES(2), .ID_VALUE(ID)) u_ws2 (
        .clk(clk), .reset(reset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]), .reg_out(reg_out[2]), .prot_err(prot_err[2]));

    always #5 clk = ~clk;

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NREG; i++) mreg[k][i] = (i == 0) ? ID : 32'h0;
            mprot[k]   = 1'b0;
            exp_rdy[k] = 1'b0;
            exp_rd[k]  = 32'h0;
            exp_err[k] = 1'b0;
        end
    endtask

    task automatic clear_exp(input int k);
        exp_rdy[k] = 1'b0;
        exp_rd[k]  = 32'h0;
        exp_err[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One APB transfer starting 1 time unit after a rising edge; ends at the same
    // point after the completing edge with the bus idle. drop_after >= 0 drops
    // psel at that access cycle instead of completing.
    task automatic xfer(input int k, input bit wr, input logic [11:0] addr,
                        input logic [31:0] data, input int drop_after = -1);
        int idx;
        bit err;
        int ws;
        idx = int'(addr[11:2]);
        err = (addr[1:0] != 2'b00) || (idx >= NREG) || (wr && idx == 0);
        ws  = ws_of(k);
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = addr;
        pwdata[k]  = data;
        clear_exp(k);
        last_lat[k] = 0;
        last_rd[k]  = 32'h0;
        last_err[k] = 1'b0;
        @(posedge clk);
        #1;
        penable[k] = 1'b1;
        for (int c = 0; c <= ws; c++) begin
            if (c == drop_after) begin
                psel[k]    = 1'b0;
                penable[k] = 1'b0;
                clear_exp(k);
                @(posedge clk);
                mprot[k] = 1'b1;
                #1;
                return;
            end
            exp_rdy[k] = (c == ws);
            exp_err[k] = (c == ws) && err;
            exp_rd[k]  = 32'h0;
            if (c == ws && !wr && !err) exp_rd[k] = mreg[k][idx];
            #3;
            if (pready[k] !== 1'b1) begin
                last_lat[k]++;
            end else begin
                last_rd[k]  = prdata[k];
                last_err[k] = pslverr[k];
            end
            @(posedge clk);
            if (c != ws) #1;
        end
        if (wr && !err) mreg[k][idx] = data;
        #1;
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
        clear_exp(k);
    endtask

    // Cycle-by-cycle comparison of every instance against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("k%0d pready", k),   32'(pready[k]),   32'(exp_rdy[k]));
            chk($sformatf("k%0d prdata", k),   prdata[k],        exp_rd[k]);
            chk($sformatf("k%0d pslverr", k),  32'(pslverr[k]),  32'(exp_err[k]));
            chk($sformatf("k%0d prot_err", k), 32'(prot_err[k]), 32'(mprot[k]));
            for (int i = 0; i < NREG; i++)
                chk($sformatf("k%0d reg_out[%0d]", k, i), reg_out[k][32*i +: 32], mreg[k][i]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            psel[k]    = 1'b0;
            penable[k] = 1'b0;
            pwrite[k]  = 1'b0;
            paddr[k]   = 12'h0;
            pwdata[k]  = 32'h0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset id word", reg_out[0][31:0], 32'hA9B0_0001);
        chk("reset prot_err", 32'(prot_err[0]), 32'h0);

        // Zero wait states: write then read back
        xfer(0, 1'b1, 12'h004, 32'hDEAD_BEEF);
        chk("t1 write latency", 32'(last_lat[0]), 32'd0);
        chk("t1 reg_out[1]", reg_out[0][63:32], 32'hDEAD_BEEF);
        xfer(0, 1'b0, 12'h004, 32'h0);
        chk("t1 read latency", 32'(last_lat[0]), 32'd0);
        chk("t1 read data", last_rd[0], 32'hDEAD_BEEF);
        chk("t1 read pslverr", 32'(last_err[0]), 32'h0);
        idle(1);

        // Three wait states: ID read, then illegal ID write
        xfer(1, 1'b0, 12'h000, 32'h0);
        chk("t2 read latency", 32'(last_lat[1]), 32'd3);
        chk("t2 id data", last_rd[1], 32'hA9B0_0001);
        xfer(1, 1'b1, 12'h000, 32'hFFFF_FFFF);
        chk("t2 id write pslverr", 32'(last_err[1]), 32'h1);
        chk("t2 id unchanged", reg_out[1][31:0], 32'hA9B0_0001);
        idle(1);

        // Decode errors: out of range write, misaligned read
        xfer(0, 1'b1, 12'h020, 32'hCAFE_F00D);
        chk("t3 oor pslverr", 32'(last_err[0]), 32'h1);
        xfer(0, 1'b0, 12'h006, 32'h0);
        chk("t3 misaligned pslverr", 32'(last_err[0]), 32'h1);
        chk("t3 misaligned data", last_rd[0], 32'h0);
        chk("t3 reg1 intact", reg_out[0][63:32], 32'hDEAD_BEEF);
        chk("t3 prot_err clear", 32'(prot_err[0]), 32'h0);

        // Back-to-back transfers, no idle cycle in between
        xfer(0, 1'b1, 12'h008, 32'h1);
        xfer(0, 1'b1, 12'h00C, 32'h2);
        xfer(0, 1'b0, 12'h008, 32'h0);
        chk("t4 read reg2", last_rd[0], 32'h1);
        xfer(0, 1'b0, 12'h00C, 32'h0);
        chk("t4 read reg3", last_rd[0], 32'h2);
        chk("t4 reg_out[2]", reg_out[0][95:64], 32'h1);
        chk("t4 reg_out[3]", reg_out[0][127:96], 32'h2);
        idle(1);

        // Two wait states: abort a write by dropping psel
        xfer(2, 1'b1, 12'h004, 32'h0000_1111);
        xfer(2, 1'b1, 12'h004, 32'h55AA_55AA, 1);
        chk("t5 prot_err set", 32'(prot_err[2]), 32'h1);
        chk("t5 no write", reg_out[2][63:32], 32'h0000_1111);
        idle(1);
        xfer(2, 1'b0, 12'h004, 32'h0);
        chk("t5 read latency", 32'(last_lat[2]), 32'd2);
        chk("t5 read data", last_rd[2], 32'h0000_1111);
        chk("t5 prot_err sticky", 32'(prot_err[2]), 32'h1);
        idle(1);

        // Reset during the access phase of a write
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b1;
        paddr[0]   = 12'h010;
        pwdata[0]  = 32'h1234_5678;
        clear_exp(0);
        @(posedge clk);
        #1;
        penable[0] = 1'b1;
        exp_rdy[0] = 1'b1;
        #1;
        chk("t6 pready before reset", 32'(pready[0]), 32'h1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6 pready async drop", 32'(pready[0]), 32'h0);
        @(posedge clk);
        #1;
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        xfer(0, 1'b0, 12'h010, 32'h0);
        chk("t6 reg4 after reset", last_rd[0], 32'h0);
        chk("t6 prot_err cleared", 32'(prot_err[2]), 32'h0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slv_regfile.md
Name: apb_slv_regfile

Overview:
Synthesizable APB3 completer (slave) that answers transfers from the team's APB master agent. It holds a bank of 32-bit registers behind a word-aligned address map and inserts a parameterised number of wait states. It reports decode errors on pslverr and flags master protocol violations on a sticky status output. It is the DUT-side counterpart used with the APB UVC on the bench, and can be reused as a generic control/status register block.

Parameters:
ADDR_W, 12, width of paddr
NUM_REGS, 8, number of 32-bit registers (2..2^(ADDR_W-2)); register 0 is read-only ID
WAIT_STATES, 0, pready-low cycles inserted in every access phase (0..15)
ID_VALUE, 32'hA9B0_0001, constant returned by register 0

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_W  byte address
pwdata  input  32  write data
prdata  output  32  read data, valid when pready=1 and pwrite=0
pready  output  1  transfer completes at the rising edge where psel & penable & pready are all 1
pslverr  output  1  error response, valid only when pready=1
reg_out  output  32*NUM_REGS  register contents; register i sits at [32i+31:32i]
prot_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, wait counter=0, registers 1..NUM_REGS-1 = 0, prot_err=0. pready, pslverr and prdata are all 0. reg_out[31:0]=ID_VALUE at all times.
- Decode: idx=paddr[ADDR_W-1:2].
  - Address is valid if paddr[1:0]==0 and idx<NUM_REGS.
  - Error if the address is invalid, or pwrite=1 and idx==0.
- FSM states: IDLE, ACCESS.
  - IDLE: when sampled psel=1 and penable=0 (setup phase), go to ACCESS, latch paddr/pwrite/pwdata, and load wcnt=WAIT_STATES.
  - IDLE: if sampled penable=1, set prot_err and stay IDLE.
  - ACCESS: if wcnt!=0, decrement wcnt and keep pready=0.
  - ACCESS: pready = psel & penable & (wcnt==0), combinational from state, counter and inputs.
  - ACCESS: on the completing edge, perform the write if there is no error, then return to IDLE.
  - Back-to-back transfers: the cycle after completion is IDLE, which can accept a new setup phase immediately. Zero idle cycles between transfers are supported.
- Latency: the access phase lasts WAIT_STATES+1 cycles. With WAIT_STATES=0, pready is high in the first access cycle.
- Read data:
  - prdata = reg[idx] when pready=1, pwrite=0 and no error.
  - prdata = 0 otherwise, including on error reads.
- pslverr = pready & error. A write with an error leaves all registers unchanged.
- Register update occurs only on the completing edge; reg_out reflects the new value from the following cycle.
- Protocol violations each set prot_err and are never cleared except by reset:
  - psel drops during ACCESS before completion: abort, go to IDLE, no write.
  - paddr, pwrite or pwdata differ from the latched values while in ACCESS: the transfer continues using the latched values.
  - penable=0 while psel=1 in ACCESS.
- Reset mid-transfer: the FSM returns to IDLE, no write commits, and pready=0 immediately (asynchronous).

Test Plan:
1. WAIT_STATES=0: write 32'hDEAD_BEEF to 0x004, then read 0x004 -> pready high in the first access cycle; prdata=DEADBEEF; pslverr=0; reg_out[63:32]=DEADBEEF the cycle after the write.
2. WAIT_STATES=3: read 0x000 -> pready low for 3 access cycles, high on the 4th with prdata=A9B00001. Then write 0x000 -> pslverr=1 and ID unchanged.
3. Out-of-range write to 0x020 (NUM_REGS=8) and misaligned read of 0x006 -> pslverr=1 for both, prdata=0, all registers unchanged, prot_err stays 0.
4. Back-to-back transfers with no idle cycle: write 0x008=1, write 0x00C=2, read 0x008 -> each completes with correct data; reg_out[95:64]=1 and reg_out[127:96]=2.
5. WAIT_STATES=2: drop psel after the 1st access cycle of a write to 0x004 -> no write, prot_err=1, FSM back to IDLE. A subsequent normal read works and prot_err stays 1.
6. Assert reset during the access phase of a write to 0x010 -> pready falls asynchronously; after reset, reg 4 reads 0 and prot_err=0.
